// File: rtl/dmem_bus_if_if.sv
// Data-memory bus signal bundle.
// The master drives the request side; the slave answers with ack/err/rdata.
interface dmem_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/dmem_bus_if.sv
// M-stage adapter to a variable-latency data memory.
// Runs one req/ack transaction per access and stalls the pipe until done.
module dmem_bus_if #(
    parameter int          TIMEOUT_CYC = 16,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] BE_WD,
    input  logic [3:0]  byte_enable,
    output logic [31:0] ReadData,
    output logic        StallMem,
    output logic        mem_fault,
    dmem_bus_if_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [CW-1:0] cnt_q;
    logic          fault_q;
    logic [31:0]   rdata_q;

    logic access;
    logic done;
    logic tmo;

    assign access = MemReadM | MemWriteM;
    assign done   = bus.bus_ack | bus.bus_err;
    assign tmo    = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (access) state_d = BUSY;
            BUSY:    if (done || tmo) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A store that also has MemReadM set is treated as a store.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && access) begin
                we_q    <= MemWriteM;
                addr_q  <= {ALUResultM[31:2], 2'b00};
                wdata_q <= BE_WD;
                be_q    <= MemWriteM ? byte_enable : 4'hF;
                cnt_q   <= '0;
                fault_q <= 1'b0;
            end else if (state_q == BUSY) begin
                if (done) begin
                    fault_q <= bus.bus_err;
                    if (!we_q) begin
                        rdata_q <= bus.bus_err ? ERR_RDATA
                                               : bus.bus_rdata;
                    end
                end else if (tmo) begin
                    fault_q <= 1'b1;
                    if (!we_q) rdata_q <= ERR_RDATA;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
        bus.bus_be    = '0;
        StallMem      = 1'b0;
        mem_fault     = 1'b0;
        unique case (state_q)
            IDLE: StallMem = n_rst & access;
            BUSY: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = we_q;
                bus.bus_addr  = addr_q;
                bus.bus_wdata = wdata_q;
                bus.bus_be    = be_q;
                StallMem      = 1'b1;
            end
            RESP:    mem_fault = fault_q;
            default: ;
        endcase
    end

    assign ReadData = rdata_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed bench for dmem_bus_if: per-cycle vector table
// plus hand-written timeout and mid-transaction reset sequences.
module tb_dmem_bus_if;

    logic        clk;
    logic        n_rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] BE_WD;
    logic [3:0]  byte_enable;
    logic [31:0] ReadData;
    logic        StallMem;
    logic        mem_fault;

    dmem_bus_if_if bus ();

    dmem_bus_if #(
        .TIMEOUT_CYC(16),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .MemReadM(MemReadM),
        .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM),
        .BE_WD(BE_WD),
        .byte_enable(byte_enable),
        .ReadData(ReadData),
        .StallMem(StallMem),
        .mem_fault(mem_fault),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        ack;
        logic        err;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [3:0]  e_be;
        logic [31:0] e_rd;
        logic        e_fault;
    } vec_t;

    localparam int NV = 25;
    vec_t v [NV];

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [31:0] addr,
        input logic [31:0] wd, input logic [3:0] be,
        input logic ack, input logic err, input logic [31:0] rdata,
        input logic st, input logic rq, input logic we,
        input logic [31:0] ea, input logic [31:0] ew,
        input logic [3:0] eb, input logic [31:0] er, input logic ef);
        vec_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wd = wd; t.be = be;
        t.ack = ack; t.err = err; t.rdata = rdata;
        t.e_stall = st; t.e_req = rq; t.e_we = we; t.e_addr = ea;
        t.e_wd = ew; t.e_be = eb; t.e_rd = er; t.e_fault = ef;
        return t;
    endfunction

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic ack,
                         input logic err, input logic [31:0] rdata);
        MemReadM      = rd;
        MemWriteM     = wr;
        ALUResultM    = addr;
        BE_WD         = wd;
        byte_enable   = be;
        bus.bus_ack   = ack;
        bus.bus_err   = err;
        bus.bus_rdata = rdata;
    endtask

    int n;

    initial begin
        checks = 0;
        errors = 0;
        n_rst  = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // load, ack on second BUSY cycle
        v[0]  = mk(0,0,32'h0,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'h0,0);
        v[1]  = mk(1,0,32'h1000_0008,0,0, 0,0,0,
                   1,0,0,0,0,0, 32'h0,0);
        v[2]  = mk(1,0,32'h1000_0008,0,0, 0,0,0,
                   1,1,0,32'h1000_0008,0,4'hF, 32'h0,0);
        v[3]  = mk(1,0,32'h1000_0008,0,0, 1,0,32'h1234_5678,
                   1,1,0,32'h1000_0008,0,4'hF, 32'h0,0);
        v[4]  = mk(1,0,32'h1000_0008,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'h1234_5678,0);
        v[5]  = mk(0,0,32'h0,0,0, 1,0,32'h99,
                   0,0,0,0,0,0, 32'h1234_5678,0);
        // store, ack in first BUSY cycle
        v[6]  = mk(0,1,32'h1000_0013,32'hAB00_0000,4'h8, 0,0,0,
                   1,0,0,0,0,0, 32'h1234_5678,0);
        v[7]  = mk(0,1,32'h1000_0013,32'hAB00_0000,4'h8,
                   1,0,32'h5555_5555,
                   1,1,1,32'h1000_0010,32'hAB00_0000,4'h8,
                   32'h1234_5678,0);
        v[8]  = mk(0,1,32'h1000_0013,32'hAB00_0000,4'h8, 0,0,0,
                   0,0,0,0,0,0, 32'h1234_5678,0);
        v[9]  = mk(0,0,32'h0,0,0, 0,1,0,
                   0,0,0,0,0,0, 32'h1234_5678,0);
        // load with err and ack together
        v[10] = mk(1,0,32'h2000_0004,0,0, 1,0,32'h77,
                   1,0,0,0,0,0, 32'h1234_5678,0);
        v[11] = mk(1,0,32'h2000_0004,0,0, 1,1,32'h0BAD_F00D,
                   1,1,0,32'h2000_0004,0,4'hF, 32'h1234_5678,0);
        v[12] = mk(1,0,32'h2000_0004,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'hDEAD_BEEF,1);
        v[13] = mk(0,0,32'h0,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'hDEAD_BEEF,0);
        // back-to-back load then store
        v[14] = mk(1,0,32'h3000_0000,0,0, 0,0,0,
                   1,0,0,0,0,0, 32'hDEAD_BEEF,0);
        v[15] = mk(1,0,32'h3000_0000,0,0, 1,0,32'hCAFE_0001,
                   1,1,0,32'h3000_0000,0,4'hF, 32'hDEAD_BEEF,0);
        v[16] = mk(1,0,32'h3000_0000,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'hCAFE_0001,0);
        v[17] = mk(0,1,32'h3000_0006,32'h0077_0000,4'h4, 0,0,0,
                   1,0,0,0,0,0, 32'hCAFE_0001,0);
        v[18] = mk(0,1,32'h3000_0006,32'h0077_0000,4'h4, 1,0,0,
                   1,1,1,32'h3000_0004,32'h0077_0000,4'h4,
                   32'hCAFE_0001,0);
        v[19] = mk(0,1,32'h3000_0006,32'h0077_0000,4'h4, 0,0,0,
                   0,0,0,0,0,0, 32'hCAFE_0001,0);
        v[20] = mk(0,0,32'h0,0,0, 1,1,32'h1,
                   0,0,0,0,0,0, 32'hCAFE_0001,0);
        // read and write both set: handled as a write
        v[21] = mk(1,1,32'h4000_0001,32'h11,4'h1, 0,0,0,
                   1,0,0,0,0,0, 32'hCAFE_0001,0);
        v[22] = mk(1,1,32'h4000_0001,32'h11,4'h1, 1,0,32'hFFFF_0000,
                   1,1,1,32'h4000_0000,32'h11,4'h1, 32'hCAFE_0001,0);
        v[23] = mk(1,1,32'h4000_0001,32'h11,4'h1, 0,0,0,
                   0,0,0,0,0,0, 32'hCAFE_0001,0);
        v[24] = mk(0,0,32'h0,0,0, 0,0,0,
                   0,0,0,0,0,0, 32'hCAFE_0001,0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, bus.bus_req}, 0);
        chk("rst_stall", {31'b0, StallMem}, 0);
        chk("rst_fault", {31'b0, mem_fault}, 0);
        chk("rst_rdata", ReadData, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(v[i].rd, v[i].wr, v[i].addr, v[i].wd, v[i].be,
                  v[i].ack, v[i].err, v[i].rdata);
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, StallMem},
                {31'b0, v[i].e_stall});
            chk($sformatf("v%0d_req", i), {31'b0, bus.bus_req},
                {31'b0, v[i].e_req});
            chk($sformatf("v%0d_we", i), {31'b0, bus.bus_we},
                {31'b0, v[i].e_we});
            chk($sformatf("v%0d_addr", i), bus.bus_addr, v[i].e_addr);
            chk($sformatf("v%0d_wdata", i), bus.bus_wdata, v[i].e_wd);
            chk($sformatf("v%0d_be", i), {28'b0, bus.bus_be},
                {28'b0, v[i].e_be});
            chk($sformatf("v%0d_rdata", i), ReadData, v[i].e_rd);
            chk($sformatf("v%0d_fault", i), {31'b0, mem_fault},
                {31'b0, v[i].e_fault});
        end

        // load that never gets an answer
        @(negedge clk);
        drive(1, 0, 32'h5000_0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        n = 0;
        while (bus.bus_req && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("tmo_req_cycles", n, 16);
        chk("tmo_rdata", ReadData, 32'hDEAD_BEEF);
        chk("tmo_fault", {31'b0, mem_fault}, 1);
        chk("tmo_stall", {31'b0, StallMem}, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("tmo_fault_pulse", {31'b0, mem_fault}, 0);
        chk("tmo_idle_req", {31'b0, bus.bus_req}, 0);

        // reset while BUSY
        @(negedge clk);
        drive(1, 0, 32'h6000_0000, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("rb_busy_req", {31'b0, bus.bus_req}, 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("rb_req", {31'b0, bus.bus_req}, 0);
        chk("rb_stall", {31'b0, StallMem}, 0);
        chk("rb_fault", {31'b0, mem_fault}, 0);
        chk("rb_rdata", ReadData, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h1);
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rb_post%0d_req", k), {31'b0, bus.bus_req}, 0);
            chk($sformatf("rb_post%0d_fault", k),
                {31'b0, mem_fault}, 0);
            chk($sformatf("rb_post%0d_rdata", k), ReadData, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
